// File: rtl/lsu_pkg.sv
// Shared operation codes and memory-access helpers for the load/store unit.
// Latency: none (package of constants and pure functions).
// Backpressure: not applicable.
package lsu_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // Shared ALU_* operation encoding used by the execute stage.
   localparam logic [5:0] ALU_ADD = 6'h00;
   localparam logic [5:0] ALU_SUB = 6'h01;
   localparam logic [5:0] ALU_LB  = 6'h10;
   localparam logic [5:0] ALU_LH  = 6'h11;
   localparam logic [5:0] ALU_LW  = 6'h12;
   localparam logic [5:0] ALU_LBU = 6'h13;
   localparam logic [5:0] ALU_LHU = 6'h14;
   localparam logic [5:0] ALU_SB  = 6'h18;
   localparam logic [5:0] ALU_SH  = 6'h19;
   localparam logic [5:0] ALU_SW  = 6'h1a;

   function automatic logic is_load(input logic [5:0] op);
      return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
             (op == ALU_LBU) || (op == ALU_LHU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
   endfunction

   // Halfword accesses need an even address, word accesses a multiple of four.
   function automatic logic misaligned_access(input logic [5:0] op, input logic [1:0] lo);
      logic half_op;
      logic word_op;
      half_op = (op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH);
      word_op = (op == ALU_LW) || (op == ALU_SW);
      return (half_op && lo[0]) || (word_op && (lo != 2'b00));
   endfunction

   function automatic logic [3:0] store_strb(input logic [5:0] op, input logic [1:0] lo);
      logic [3:0] strb;
      strb = 4'b0000;
      case (op)
         ALU_SB:  strb = 4'b0001 << lo;
         ALU_SH:  strb = 4'b0011 << {lo[1], 1'b0};
         ALU_SW:  strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Sub-word stores replicate the data across every lane; the strobes pick the lane.
   function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] d);
      logic [31:0] lanes;
      lanes = d;
      case (op)
         ALU_SB:  lanes = {4{d[7:0]}};
         ALU_SH:  lanes = {2{d[15:0]}};
         default: lanes = d;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero-extends it.
// Latency: purely combinational. Backpressure: none.
// Ports: alucode (load op), addr (low two address bits), mem_rdata (read word), result (aligned value).
module load_align
   import lsu_pkg::*;
(
   input  logic [5:0]  alucode,
   input  logic [1:0]  addr,
   input  logic [31:0] mem_rdata,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = mem_rdata[7:0];
      case (addr)
         2'd0:    byte_lane = mem_rdata[7:0];
         2'd1:    byte_lane = mem_rdata[15:8];
         2'd2:    byte_lane = mem_rdata[23:16];
         default: byte_lane = mem_rdata[31:24];
      endcase
      half_lane = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      result = 32'h0;
      case (alucode)
         ALU_LB:  result = {{24{byte_lane[7]}}, byte_lane};
         ALU_LBU: result = {24'h0, byte_lane};
         ALU_LH:  result = {{16{half_lane[15]}}, half_lane};
         ALU_LHU: result = {16'h0, half_lane};
         ALU_LW:  result = mem_rdata;
         default: result = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request in flight, IDLE -> BUS -> RESP, with alignment and bus-timeout faults.
// Latency: result valid one cycle after mem_ack (bus ops) or one cycle after accept (non-bus/faults).
// Backpressure: req_ready only in IDLE; RESP holds the result until resp_ready.
// Ports: clk/rst; req_* execute request (alucode, addr, store_data, rd_in);
//        mem_* data-memory request/ack; resp_* writeback with misaligned/bus_err fault flags.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  alucode,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        misaligned,
   output logic        bus_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Abort on the edge that completes the TIMEOUT_CYCLES-th BUS cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t           state;
   logic [5:0]       op_q;
   logic [31:0]      addr_q;
   logic [31:0]      data_q;
   logic [4:0]       rd_q;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      load_result;

   assign req_ready = (state == IDLE);

   // Address and write data come straight from the captured request, so they
   // are stable for the whole BUS phase by construction.
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = store_lanes(op_q, data_q);

   load_align u_load_align (
      .alucode   (op_q),
      .addr      (addr_q[1:0]),
      .mem_rdata (mem_rdata),
      .result    (load_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op_q       <= ALU_ADD;
         addr_q     <= '0;
         data_q     <= '0;
         rd_q       <= '0;
         cnt        <= '0;
         mem_req    <= DISABLE;
         mem_we     <= DISABLE;
         mem_wstrb  <= '0;
         resp_valid <= DISABLE;
         resp_data  <= '0;
         resp_rd    <= '0;
         misaligned <= DISABLE;
         bus_err    <= DISABLE;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q       <= alucode;
                  addr_q     <= addr;
                  data_q     <= store_data;
                  rd_q       <= rd_in;
                  cnt        <= '0;
                  resp_rd    <= rd_in;
                  misaligned <= DISABLE;
                  bus_err    <= DISABLE;
                  if (is_load(alucode) || is_store(alucode)) begin
                     if (misaligned_access(alucode, addr[1:0])) begin
                        state      <= RESP;
                        resp_valid <= ENABLE;
                        resp_data  <= '0;
                        misaligned <= ENABLE;
                     end else begin
                        state     <= BUS;
                        mem_req   <= ENABLE;
                        mem_we    <= is_store(alucode);
                        mem_wstrb <= store_strb(alucode, addr[1:0]);
                     end
                  end else begin
                     // Non-memory op: the ALU result is the writeback value.
                     state      <= RESP;
                     resp_valid <= ENABLE;
                     resp_data  <= addr;
                  end
               end
            end

            BUS: begin
               // Ack is checked first so it wins over a timeout on the same edge.
               if (mem_ack) begin
                  state      <= RESP;
                  mem_req    <= DISABLE;
                  mem_we     <= DISABLE;
                  mem_wstrb  <= '0;
                  resp_valid <= ENABLE;
                  resp_data  <= is_store(op_q) ? 32'h0 : load_result;
                  resp_rd    <= rd_q;
               end else if (cnt == CNT_LAST) begin
                  state      <= RESP;
                  mem_req    <= DISABLE;
                  mem_we     <= DISABLE;
                  mem_wstrb  <= '0;
                  resp_valid <= ENABLE;
                  resp_data  <= '0;
                  resp_rd    <= rd_q;
                  bus_err    <= ENABLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= DISABLE;
                  misaligned <= DISABLE;
                  bus_err    <= DISABLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: reset values, loads/stores, faults, timeout, backpressure, mid-BUS reset.
// Latency: inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Backpressure: resp_ready held low except when a response is explicitly released.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  alucode;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [4:0]  rd_in;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        misaligned;
   logic        bus_err;

   int n_pass  = 0;
   int n_total = 0;
   int hi;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT_CYCLES(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .alucode    (alucode),
      .addr       (addr),
      .store_data (store_data),
      .rd_in      (rd_in),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .misaligned (misaligned),
      .bus_err    (bus_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single edge; the bench only calls this in IDLE.
   task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd);
      alucode    = op;
      addr       = a;
      store_data = d;
      rd_in      = rd;
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
   endtask

   task automatic release_resp();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time=%0t limit=100000", $time);
      $fatal(1, "simulation did not finish");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; alucode = ALU_ADD; addr = '0; store_data = '0;
      rd_in = '0; mem_ack = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_req_ready",  req_ready,  1);
      check("rst_mem_req",    mem_req,    0);
      check("rst_mem_we",     mem_we,     0);
      check("rst_mem_wstrb",  mem_wstrb,  0);
      check("rst_mem_addr",   mem_addr,   0);
      check("rst_mem_wdata",  mem_wdata,  0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data",  resp_data,  0);
      check("rst_resp_rd",    resp_rd,    0);
      check("rst_misaligned", misaligned, 0);
      check("rst_bus_err",    bus_err,    0);

      // LB lane 3, sign-extended, ack after two bus cycles
      send(ALU_LB, 32'h0000_1003, 32'h0, 5'd5);
      check("lb_mem_req",    mem_req,   1);
      check("lb_mem_addr",   mem_addr,  32'h0000_1000);
      check("lb_mem_wstrb",  mem_wstrb, 0);
      check("lb_mem_we",     mem_we,    0);
      check("lb_req_ready",  req_ready, 0);
      tick();
      check("lb_hold_req",   mem_req,   1);
      check("lb_hold_addr",  mem_addr,  32'h0000_1000);
      check("lb_no_resp",    resp_valid, 0);
      mem_rdata = 32'h80FF_1234;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      check("lb_resp_valid", resp_valid, 1);
      check("lb_resp_data",  resp_data,  32'hFFFF_FF80);
      check("lb_resp_rd",    resp_rd,    5);
      check("lb_req_drop",   mem_req,    0);
      check("lb_flags",      {misaligned, bus_err}, 0);
      release_resp();
      check("lb_done_valid", resp_valid, 0);
      check("lb_done_ready", req_ready,  1);

      // SH upper half
      send(ALU_SH, 32'h0000_2002, 32'h0000_ABCD, 5'd7);
      check("sh_mem_we",    mem_we,    1);
      check("sh_mem_wstrb", mem_wstrb, 4'b1100);
      check("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
      check("sh_mem_addr",  mem_addr,  32'h0000_2000);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("sh_resp_valid", resp_valid, 1);
      check("sh_resp_data",  resp_data,  0);
      check("sh_resp_rd",    resp_rd,    7);
      check("sh_we_drop",    mem_we,     0);
      release_resp();

      // SB lane 1
      send(ALU_SB, 32'h0000_7001, 32'h1234_565A, 5'd3);
      check("sb_mem_wstrb", mem_wstrb, 4'b0010);
      check("sb_mem_wdata", mem_wdata, 32'h5A5A_5A5A);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("sb_resp_data", resp_data, 0);
      release_resp();

      // Misaligned LW: no bus access, response at N+1
      send(ALU_LW, 32'h0000_3001, 32'h0, 5'd9);
      check("lwm_mem_req",    mem_req,    0);
      check("lwm_resp_valid", resp_valid, 1);
      check("lwm_misaligned", misaligned, 1);
      check("lwm_resp_data",  resp_data,  0);
      check("lwm_bus_err",    bus_err,    0);
      tick();
      check("lwm_still_no_req", mem_req,  0);
      release_resp();

      // LH lane 1, sign-extended
      send(ALU_LH, 32'h0000_8002, 32'h0, 5'd4);
      mem_rdata = 32'h8001_7FFF;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      check("lh_resp_data", resp_data, 32'hFFFF_8001);
      release_resp();

      // LBU lane 2, zero-extended
      send(ALU_LBU, 32'h0000_9002, 32'h0, 5'd8);
      mem_rdata = 32'h80FF_1234;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      check("lbu_resp_data", resp_data, 32'h0000_00FF);
      release_resp();

      // LHU with no ack: timeout after exactly 8 mem_req cycles
      send(ALU_LHU, 32'h0000_4000, 32'h0, 5'd2);
      hi = 0;
      while (mem_req === 1'b1 && hi < 20) begin
         hi++;
         tick();
      end
      check("to_req_cycles",  32'(hi),    8);
      check("to_resp_valid",  resp_valid, 1);
      check("to_bus_err",     bus_err,    1);
      check("to_resp_data",   resp_data,  0);
      check("to_misaligned",  misaligned, 0);
      release_resp();
      check("to_clear_err",   bus_err,    0);

      // Ack on the timeout edge wins
      send(ALU_LW, 32'h0000_5000, 32'h0, 5'd6);
      repeat (7) tick();
      check("race_req_held",  mem_req,    1);
      mem_rdata = 32'hDEAD_BEEF;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      check("race_resp_valid", resp_valid, 1);
      check("race_bus_err",    bus_err,    0);
      check("race_resp_data",  resp_data,  32'hDEAD_BEEF);
      release_resp();

      // ADD pass-through held under backpressure; no accept while in RESP
      send(ALU_ADD, 32'h1234_5678, 32'h0, 5'd10);
      check("add_valid_c1", resp_valid, 1);
      check("add_data_c1",  resp_data,  32'h1234_5678);
      check("add_ready_c1", req_ready,  0);
      alucode   = ALU_ADD;
      addr      = 32'hCAFE_F00D;
      req_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("add_valid_hold", resp_valid, 1);
         check("add_data_hold",  resp_data,  32'h1234_5678);
         check("add_ready_hold", req_ready,  0);
      end
      check("add_resp_rd", resp_rd, 10);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check("add_release_valid", resp_valid, 0);
      check("add_release_ready", req_ready,  1);
      tick();
      check("add_no_accept", resp_valid, 0);

      // Reset during BUS, then a stray ack
      send(ALU_LB, 32'h0000_6000, 32'h0, 5'd1);
      check("rb_mem_req", mem_req, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rb_req_drop",   mem_req,    0);
      check("rb_req_ready",  req_ready,  1);
      check("rb_resp_valid", resp_valid, 0);
      check("rb_wstrb",      mem_wstrb,  0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("stray_ack_resp", resp_valid, 0);
      check("stray_ack_req",  mem_req,    0);
      tick();
      check("stray_ack_later", resp_valid, 0);

      // Reset during RESP
      send(ALU_LW, 32'h0000_3002, 32'h0, 5'd9);
      check("rr_pre_valid", resp_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rr_resp_valid", resp_valid, 0);
      check("rr_misaligned", misaligned, 0);
      check("rr_req_ready",  req_ready,  1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
